// File: rtl/gpu_cmd_engine_pkg.sv
// Shared constants and types for the 6502-facing GPU command engine:
// opcodes, register selects, status bit positions and FSM states.
package gpu_pkg;

  localparam logic [7:0] OP_PLOT    = 8'h00;
  localparam logic [7:0] OP_FILL    = 8'h01;
  localparam logic [7:0] OP_PLOTINC = 8'h02;
  localparam logic [7:0] OP_CLR_OVF = 8'hFF;

  localparam logic [1:0] RS_COLOR = 2'd0;
  localparam logic [1:0] RS_X     = 2'd1;
  localparam logic [1:0] RS_Y     = 2'd2;
  localparam logic [1:0] RS_CMD   = 2'd3;

  localparam int ST_BLANK = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLOT = 2'd1,
    FILL = 2'd2
  } state_e;

endpackage

// File: rtl/gpu_cmd_engine_if.sv
// Pixel write stream from the command engine to the framebuffer port.
// Handshake: PIX_VALID rises with X/Y/COLOR stable; a pixel transfers on every
// clock edge where PIX_VALID and PIX_READY are both 1; fields hold until then.
interface gpu_cmd_engine_if #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 3
);
  logic               PIX_VALID;
  logic               PIX_READY;
  logic [COORD_W-1:0] PIX_X;
  logic [COORD_W-1:0] PIX_Y;
  logic [COLOR_W-1:0] PIX_COLOR;

  modport master (output PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, input PIX_READY);
  modport slave  (input PIX_VALID, PIX_X, PIX_Y, PIX_COLOR, output PIX_READY);
endinterface

// File: rtl/gpu_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered occupancy count.
// A pop in the same cycle as a push on a full FIFO frees the slot first.
module gpu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/gpu_cmd_engine.sv
// 6502 register port that queues PLOT/FILL commands and streams them out as
// framebuffer pixel writes. CPU_CLOCK is sampled as data in the SYS_CLOCK domain.
module gpu_cmd_engine
  import gpu_pkg::*;
#(
  parameter int COORD_W    = 8,
  parameter int COLOR_W    = 3,
  parameter int X_MAX      = 159,
  parameter int Y_MAX      = 119,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                SYS_CLOCK,
  input  logic                RESET,
  input  logic                CPU_CLOCK,
  input  logic                CE,
  input  logic                RWB,
  input  logic [1:0]          RS,
  input  logic [7:0]          DATA_IN,
  output logic [7:0]          DATA_OUT,
  output logic                DATA_OE,
  input  logic                ON_SCREEN,
  gpu_cmd_engine_if.master    pix,
  output state_e              DBG_STATE
);
  localparam int EW = 1 + 2 * COORD_W + COLOR_W;
  localparam logic [COORD_W-1:0] XM = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YM = COORD_W'(Y_MAX);

  logic               phi_meta_q, phi_s_q, phi_d_q;
  logic               sh_ce_q, sh_rwb_q;
  logic [1:0]         sh_rs_q;
  logic [7:0]         sh_data_q;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         rd_q, rd_d;
  state_e             state_q;
  logic               valid_q;
  logic [COORD_W-1:0] px_q, py_q;
  logic [COLOR_W-1:0] pc_q;

  logic               commit, is_cmd, push_req, accept, pop, done, last, busy;
  logic               fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic [EW-1:0]      fifo_wdata, fifo_rdata;

  // Shadows follow the bus while PHI2 is high; the falling edge freezes them.
  always_ff @(posedge SYS_CLOCK) begin
    if (RESET) begin
      phi_meta_q <= 1'b0;
      phi_s_q    <= 1'b0;
      phi_d_q    <= 1'b0;
      sh_ce_q    <= 1'b0;
      sh_rwb_q   <= 1'b0;
      sh_rs_q    <= '0;
      sh_data_q  <= '0;
    end else begin
      phi_meta_q <= CPU_CLOCK;
      phi_s_q    <= phi_meta_q;
      phi_d_q    <= phi_s_q;
      if (phi_s_q) begin
        sh_ce_q   <= CE;
        sh_rwb_q  <= RWB;
        sh_rs_q   <= RS;
        sh_data_q <= DATA_IN;
      end
    end
  end

  assign commit   = phi_d_q & ~phi_s_q & ~sh_ce_q & ~sh_rwb_q;
  assign is_cmd   = commit && (sh_rs_q == RS_CMD);
  assign push_req = is_cmd && (sh_data_q == OP_PLOT || sh_data_q == OP_FILL ||
                               sh_data_q == OP_PLOTINC);
  assign accept   = push_req && (!fifo_full || pop);
  assign fifo_wdata = {sh_data_q == OP_FILL, x_q, y_q, color_q};

  always_comb begin
    color_d = color_q;
    x_d     = x_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    if (commit && sh_rs_q == RS_COLOR) color_d = sh_data_q[COLOR_W-1:0];
    if (commit && sh_rs_q == RS_X)     x_d     = sh_data_q[COORD_W-1:0];
    if (commit && sh_rs_q == RS_Y)     y_d     = sh_data_q[COORD_W-1:0];
    if (is_cmd && sh_data_q == OP_CLR_OVF) ovf_d = 1'b0;
    if (push_req && !accept) ovf_d = 1'b1;
    // Auto-increment only when the PLOT actually made it into the queue.
    if (accept && sh_data_q == OP_PLOTINC) begin
      if (x_q == XM) begin
        x_d = '0;
        y_d = (y_q == YM) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  assign busy = (fifo_count != '0) || (state_q != IDLE);

  always_comb begin
    rd_d = 8'h00;
    case (RS)
      RS_COLOR: rd_d = 8'(color_q);
      RS_X:     rd_d = 8'(x_q);
      RS_Y:     rd_d = 8'(y_q);
      default: begin
        rd_d[ST_OVF]   = ovf_q;
        rd_d[ST_FULL]  = fifo_full;
        rd_d[ST_BUSY]  = busy;
        rd_d[ST_BLANK] = ~ON_SCREEN;
      end
    endcase
  end

  always_ff @(posedge SYS_CLOCK) begin
    if (RESET) begin
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      color_q <= color_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  gpu_cmd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (SYS_CLOCK),
    .rst   (RESET),
    .push  (accept),
    .pop   (pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign last = (px_q == XM) && (py_q == YM);
  assign done = valid_q && pix.PIX_READY &&
                (state_q == PLOT || (state_q == FILL && last));
  // Popping on the finishing beat keeps back-to-back commands at one beat per cycle.
  assign pop  = !fifo_empty && (state_q == IDLE || done);

  always_ff @(posedge SYS_CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: ;
        PLOT: if (pix.PIX_READY) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        FILL: if (pix.PIX_READY) begin
          if (last) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else if (px_q == XM) begin
            px_q <= '0;
            py_q <= py_q + 1'b1;
          end else begin
            px_q <= px_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (pop) begin
        valid_q <= 1'b1;
        pc_q    <= fifo_rdata[COLOR_W-1:0];
        if (fifo_rdata[EW-1]) begin
          state_q <= FILL;
          px_q    <= '0;
          py_q    <= '0;
        end else begin
          state_q <= PLOT;
          px_q    <= fifo_rdata[COLOR_W+2*COORD_W-1 -: COORD_W];
          py_q    <= fifo_rdata[COLOR_W+COORD_W-1 -: COORD_W];
        end
      end
    end
  end

  assign pix.PIX_VALID = valid_q;
  assign pix.PIX_X     = px_q;
  assign pix.PIX_Y     = py_q;
  assign pix.PIX_COLOR = pc_q;
  assign DATA_OUT      = rd_q;
  assign DATA_OE       = ~CE & RWB & CPU_CLOCK;
  assign DBG_STATE     = state_q;
endmodule
